// File: rtl/sync_updown_counter.sv
// -----------------------------------------------------------------------------
// sync_updown_counter
//
// Synchronous modulo-MODULUS up/down counter. Besides holding the count, it
// exposes the per-bit toggle mask (the J=K excitation of an equivalent
// JK-flip-flop counter), a combinational cascade carry/borrow, and a
// saturating count of wrap-arounds.
//
// Parameters:
//   WIDTH    counter width in bits (1..16)
//   MODULUS  count modulus (2..2^WIDTH); sequence is 0..MODULUS-1
//   WRAPW    width of the saturating wrap counter
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset (clears count and wraps)
//   en         in   count enable, one step per edge
//   up         in   direction, 1 = increment, 0 = decrement
//   load       in   parallel load strobe (beats en)
//   load_val   in   value taken on load, clamped to MODULUS-1
//   clr_wraps  in   synchronous clear of the wrap counter
//   count      out  registered count
//   toggle     out  bits that flip on the next counting step (combinational)
//   carry      out  high in the cycle whose edge wraps the count (comb.)
//   wraps      out  saturating number of wrap-arounds (registered)
// -----------------------------------------------------------------------------
module sync_updown_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10,
  parameter int WRAPW   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_wraps,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] toggle,
  output logic             carry,
  output logic [WRAPW-1:0] wraps
);

  // Reject an out-of-range configuration while elaborating rather than
  // silently producing a counter with an odd sequence.
  if (WIDTH < 1 || WIDTH > 16 || MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_param
    $error("sync_updown_counter: illegal WIDTH/MODULUS combination");
  end

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WRAPW-1:0] wraps_q, wraps_d;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] load_clamped;
  logic             at_end;

  // at_end marks the terminal value for the current direction: the next
  // step from here wraps the sequence.
  always_comb begin
    at_end = up ? (count_q == MAX_VAL) : (count_q == '0);
    if (up) begin
      nxt = at_end ? '0 : count_q + WIDTH'(1);
    end else begin
      nxt = at_end ? MAX_VAL : count_q - WIDTH'(1);
    end
  end

  // Compare in 32 bits so MODULUS = 2^WIDTH never clamps anything.
  assign load_clamped = (32'(load_val) >= MODULUS) ? MAX_VAL : load_val;

  assign carry  = en & ~rst & ~load & at_end;
  assign toggle = count_q ^ nxt;

  always_comb begin
    count_d = count_q;
    wraps_d = wraps_q;
    if (load) begin
      count_d = load_clamped;
    end else if (en) begin
      count_d = nxt;
    end
    // clr_wraps wins over a wrap in the same cycle; the counter sticks at
    // all-ones once saturated.
    if (clr_wraps) begin
      wraps_d = '0;
    end else if (carry && (wraps_q != '1)) begin
      wraps_d = wraps_q + WRAPW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      wraps_q <= '0;
    end else begin
      count_q <= count_d;
      wraps_q <= wraps_d;
    end
  end

  assign count = count_q;
  assign wraps = wraps_q;

endmodule

// File: tb/tb_sync_updown_counter.sv
// -----------------------------------------------------------------------------
// tb_sync_updown_counter
//
// Two instances share one set of inputs: a decade counter (MODULUS 10,
// WRAPW 8) and a full-range hex counter (MODULUS 16, WRAPW 2). A separate
// pair of decade counters forms a two-digit cascade. Expected values come
// from modular-arithmetic models of each instance plus literal values for
// the directed scenarios.
// -----------------------------------------------------------------------------
module tb_sync_updown_counter;

  localparam int W  = 4;
  localparam int MA = 10;
  localparam int WA = 8;
  localparam int MB = 16;
  localparam int WB = 2;

  // ---------------- clock ----------------
  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- shared stimulus ----------------
  logic         rst, en, up, load, clr_wraps;
  logic [W-1:0] load_val;

  logic [W-1:0]  count_a, toggle_a, count_b, toggle_b;
  logic          carry_a, carry_b;
  logic [WA-1:0] wraps_a;
  logic [WB-1:0] wraps_b;

  sync_updown_counter #(.WIDTH(W), .MODULUS(MA), .WRAPW(WA)) dut_a (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .clr_wraps(clr_wraps), .count(count_a), .toggle(toggle_a), .carry(carry_a),
    .wraps(wraps_a)
  );

  sync_updown_counter #(.WIDTH(W), .MODULUS(MB), .WRAPW(WB)) dut_b (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .clr_wraps(clr_wraps), .count(count_b), .toggle(toggle_b), .carry(carry_b),
    .wraps(wraps_b)
  );

  // ---------------- cascade pair ----------------
  logic          c_rst, c_en;
  logic [W-1:0]  c_count0, c_count1, c_tog0, c_tog1;
  logic          c_carry0, c_carry1;
  logic [WA-1:0] c_wraps0, c_wraps1;

  sync_updown_counter #(.WIDTH(W), .MODULUS(10), .WRAPW(WA)) dut_c0 (
    .clk(clk), .rst(c_rst), .en(c_en), .up(1'b1), .load(1'b0), .load_val(4'd0),
    .clr_wraps(1'b0), .count(c_count0), .toggle(c_tog0), .carry(c_carry0),
    .wraps(c_wraps0)
  );

  sync_updown_counter #(.WIDTH(W), .MODULUS(10), .WRAPW(WA)) dut_c1 (
    .clk(clk), .rst(c_rst), .en(c_carry0), .up(1'b1), .load(1'b0), .load_val(4'd0),
    .clr_wraps(1'b0), .count(c_count1), .toggle(c_tog1), .carry(c_carry1),
    .wraps(c_wraps1)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;

  int ma_c = 0, ma_w = 0;
  int mb_c = 0, mb_w = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int nxt_of(input int c, input bit u, input int m);
    return u ? (c + 1) % m : (c + m - 1) % m;
  endfunction

  function automatic bit at_end(input int c, input bit u, input int m);
    return u ? (c == m - 1) : (c == 0);
  endfunction

  function automatic bit exp_carry(input int c, input int m);
    return en && !rst && !load && at_end(c, up, m);
  endfunction

  task automatic advance(inout int c, inout int w, input int m, input int wmax);
    bit cy;
    cy = exp_carry(c, m);
    if (rst) begin
      c = 0;
      w = 0;
    end else begin
      if (load)    c = (int'(load_val) >= m) ? m - 1 : int'(load_val);
      else if (en) c = nxt_of(c, up, m);
      if (clr_wraps)              w = 0;
      else if (cy && (w < wmax))  w++;
    end
  endtask

  task automatic check_model();
    check_eq("a_count",  count_a,  ma_c);
    check_eq("a_wraps",  wraps_a,  ma_w);
    check_eq("a_toggle", toggle_a, ma_c ^ nxt_of(ma_c, up, MA));
    check_eq("a_carry",  carry_a,  exp_carry(ma_c, MA));
    check_eq("b_count",  count_b,  mb_c);
    check_eq("b_wraps",  wraps_b,  mb_w);
    check_eq("b_toggle", toggle_b, mb_c ^ nxt_of(mb_c, up, MB));
    check_eq("b_carry",  carry_b,  exp_carry(mb_c, MB));
  endtask

  // ---------------- driver tasks ----------------
  // Called just after a falling edge: drive, settle, check against the model.
  task automatic set_in(input bit r, input bit e, input bit u, input bit l,
                        input int lv, input bit cw);
    rst = r; en = e; up = u; load = l; load_val = W'(lv); clr_wraps = cw;
    #1;
    check_model();
  endtask

  // Take one rising edge and bring the models along with it.
  task automatic tick();
    @(posedge clk);
    advance(ma_c, ma_w, MA, (1 << WA) - 1);
    advance(mb_c, mb_w, MB, (1 << WB) - 1);
    @(negedge clk);
  endtask

  task automatic do_load(input int lv);
    set_in(0, 0, 1, 1, lv, 0);
    tick();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int hits;
    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0; clr_wraps = 1'b0;
    c_rst = 1'b1; c_en = 1'b0;
    @(negedge clk);
    tick();
    tick();

    // Reset state
    set_in(0, 0, 1, 0, 0, 0);
    check_eq("rst_count",  count_a,  0);
    check_eq("rst_wraps",  wraps_a,  0);
    check_eq("rst_toggle", toggle_a, 1);
    check_eq("rst_carry",  carry_a,  0);

    // Up count through one wrap
    for (int i = 0; i < 12; i++) begin
      set_in(0, 1, 1, 0, 0, 0);
      check_eq("up_seq_count", count_a, i % 10);
      check_eq("up_seq_carry", carry_a, (i == 9));
      tick();
    end
    check_eq("up_end_count", count_a, 2);
    check_eq("up_end_wraps", wraps_a, 1);

    // Down wrap from 0
    do_load(0);
    for (int i = 0; i < 3; i++) begin
      set_in(0, 1, 0, 0, 0, 0);
      check_eq("dn_seq_count", count_a, (10 - i) % 10);
      check_eq("dn_seq_carry", carry_a, (i == 0));
      tick();
    end
    check_eq("dn_end_count", count_a, 7);
    check_eq("dn_end_wraps", wraps_a, 2);

    // Load and clamp
    do_load(6);
    check_eq("load6_count", count_a, 6);
    check_eq("load6_wraps", wraps_a, 2);
    do_load(13);
    check_eq("clamp_count_a", count_a, 9);
    check_eq("noclamp_count_b", count_b, 13);
    set_in(0, 1, 1, 1, 3, 0);
    check_eq("load_en_carry", carry_a, 0);
    tick();
    check_eq("load_en_count", count_a, 3);
    check_eq("load_en_wraps", wraps_a, 2);

    // Toggle masks on the hex instance
    do_load(7);
    set_in(0, 0, 1, 0, 0, 0);
    check_eq("tog_0111_up", toggle_b, 4'b1111);
    do_load(8);
    set_in(0, 0, 0, 0, 0, 0);
    check_eq("tog_1000_dn", toggle_b, 4'b1111);
    do_load(5);
    set_in(0, 0, 1, 0, 0, 0);
    check_eq("tog_0101_up", toggle_b, 4'b0011);
    do_load(15);
    set_in(0, 0, 1, 0, 0, 0);
    check_eq("tog_1111_up", toggle_b, 4'b1111);
    check_eq("carry_1111_en0", carry_b, 0);
    set_in(0, 1, 1, 0, 0, 0);
    check_eq("carry_1111_en1", carry_b, 1);
    tick();
    check_eq("rollover_count_b", count_b, 0);

    // Saturation of the 2-bit wrap counter
    set_in(0, 0, 1, 0, 0, 1);
    tick();
    check_eq("clr_wraps_b", wraps_b, 0);
    repeat (80) begin
      set_in(0, 1, 1, 0, 0, 0);
      tick();
    end
    check_eq("sat_wraps_b", wraps_b, 3);

    // clr_wraps coinciding with a wrap
    do_load(15);
    set_in(0, 1, 1, 0, 0, 1);
    check_eq("clr_wrap_carry_b", carry_b, 1);
    tick();
    check_eq("clr_wrap_wraps_b", wraps_b, 0);
    check_eq("clr_wrap_wraps_a", wraps_a, 0);
    check_eq("clr_wrap_count_b", count_b, 0);

    // Reset beating load and en
    do_load(15);
    set_in(0, 1, 1, 0, 0, 0);
    tick();
    check_eq("pre_rst_wraps_b", wraps_b, 1);
    do_load(5);
    set_in(1, 1, 1, 1, 7, 0);
    tick();
    check_eq("rst_mid_count_a", count_a, 0);
    check_eq("rst_mid_wraps_a", wraps_a, 0);
    check_eq("rst_mid_count_b", count_b, 0);
    check_eq("rst_mid_wraps_b", wraps_b, 0);
    set_in(0, 1, 1, 0, 0, 0);
    tick();
    check_eq("resume_count_a", count_a, 1);

    // Randomized traffic against the model
    repeat (1500) begin
      set_in($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0,
             $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0,
             int'($urandom_range(0, 15)), $urandom_range(0, 31) == 0);
      tick();
    end

    // Two-digit cascade
    set_in(0, 0, 1, 0, 0, 0);
    tick();
    tick();
    c_rst = 1'b0;
    c_en  = 1'b1;
    hits  = 0;
    for (int i = 0; i < 100; i++) begin
      #1;
      check_eq("cascade_pair", 32'(c_count1) * 10 + 32'(c_count0), i);
      check_eq("cascade_carry1", c_carry1, (i == 99));
      if (c_carry1) hits++;
      tick();
    end
    #1;
    check_eq("cascade_final_pair", 32'(c_count1) * 10 + 32'(c_count0), 0);
    check_eq("cascade_carry1_hits", hits, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sync_updown_counter.md
# sync_updown_counter

Synchronous modulo-N up/down counter for the synchronous counter design. It computes the per-bit toggle mask that drives the J=K inputs of a JK-flip-flop counter stage, and it holds the resulting count in its own state register. It provides parallel load, count enable, a cascade carry output and a saturating wrap counter.

## Interface
- WIDTH, 4, counter width in bits (1..16)
- MODULUS, 10, count modulus; legal range 2..2^WIDTH; count sequence is 0..MODULUS-1
- WRAPW, 8, width of the wrap counter
- clk  in  1  rising-edge clock; the only clock
- rst  in  1  synchronous, active-high reset
- en  in  1  count enable; one step per rising edge while high
- up  in  1  direction: 1 = increment, 0 = decrement
- load  in  1  parallel load strobe
- load_val  in  WIDTH  value taken on load
- clr_wraps  in  1  synchronous clear of wraps
- count  out  WIDTH  current count (registered)
- toggle  out  WIDTH  bits that flip on the next counting step (combinational) = J/K excitation
- carry  out  1  cascade carry/borrow (combinational)
- wraps  out  WRAPW  number of wrap-arounds since reset/clear, saturating (registered)

## Operation
- Next-step value nxt, computed for the current up:
  - up=1: count==MODULUS-1 ? 0 : count+1.
  - up=0: count==0 ? MODULUS-1 : count-1.
  - All arithmetic is WIDTH bits; no intermediate overflow is ever exposed.
- toggle = count XOR nxt.
  - Depends only on count and up; it does not depend on en or load.
  - Equals the J=K terms of a JK counter. Example: count=0111, up=1 (MODULUS 16) gives toggle=1111.
- carry = en & !rst & !load & (up ? count==MODULUS-1 : count==0). It is high exactly in the cycle whose edge wraps the count.
- Priority at each rising edge is rst > load > en:
  - rst: count<=0, wraps<=0.
  - load: count<=load_val. If load_val >= MODULUS, count<=MODULUS-1 (clamp). Load never increments wraps.
  - en (no load): count<=nxt. If carry is high, wraps<=wraps+1, saturating at 2^WRAPW-1.
  - otherwise: count holds.
- clr_wraps (below rst, above the wraps increment): wraps<=0 at that edge, even when a wrap occurs in the same cycle.
- up may change on any cycle; the step taken always uses the up value sampled at that edge.
- Behaviour is undefined for a MODULUS outside the legal range; the implementation flags it with an elaboration-time error.

## Timing
- Reset values: count=0, wraps=0, toggle=0…01 for up=1 (toggle for up=0 follows the formula), carry=0.
- Latency:
  - en or load sampled at edge N is reflected in count after edge N, i.e. in cycle N+1.
  - toggle and carry respond combinationally within the same cycle.
- rst asserted mid-count overrides load and en in the same cycle. Counting resumes from 0 on the first edge with rst low and en high.
- Simultaneous load and en: load wins, no step, no wrap counted.
- Simultaneous load and rst: count=0.
- Boundaries:
  - Down from 0 yields MODULUS-1.
  - Up from MODULUS-1 yields 0.
  - With MODULUS=2^WIDTH, the wrap is natural rollover.
- Cascading: the carry of stage k feeds en of stage k+1 (same clk). This gives a single-clock synchronous multi-digit counter with no ripple between stages.

## Test plan
- Reset/up count, WIDTH=4, MODULUS=10:
  - Stimulus: rst for 2 cycles, then en=1, up=1 for 12 cycles.
  - Required: count 0,1,…,9,0,1,2; carry high only in the cycle with count=9; wraps=1.
- Down wrap:
  - Stimulus: from count=0, en=1, up=0 for 3 cycles.
  - Required: count 9,8,7; carry high in the first cycle (count=0); wraps increments by 1.
- Load and clamp:
  - Stimulus: load=1, load_val=6.
  - Required: count=6 next cycle, wraps unchanged.
  - Stimulus: load_val=13.
  - Required: count=9.
  - Stimulus: load=1 and en=1 at count=9, up=1.
  - Required: count=load_val, carry=0.
- Toggle mask, MODULUS=16:
  - count=0111, up=1: toggle=1111.
  - count=1000, up=0: toggle=1111.
  - count=0101, up=1: toggle=0011.
  - count=1111, up=1: toggle=1111, carry=en.
- Reset mid-operation and saturation, WRAPW=2:
  - Stimulus: force 5 wraps.
  - Required: wraps saturates at 3.
  - Stimulus: clr_wraps together with a wrap.
  - Required: wraps=0.
  - Stimulus: rst while en=1 and load=1.
  - Required: count=0, wraps=0 next cycle.
- Cascade:
  - Stimulus: two instances (MODULUS=10), stage 0 carry drives stage 1 en, run 100 cycles with up=1.
  - Required: the pair reads 00…99, then 00; stage 1 carry is high in exactly one cycle (count pair 99).
